// File: rtl/outport_unit.sv
// Output-port peripheral: edge-captures bus words into a small FIFO and hands them to a device
// over valid/ready. Optional per-entry even parity on dev_data when OUTPORT_PARITY_EN is defined.
module outport_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  outport_enable,
    input  logic [DATA_WIDTH-1:0] bus_Data,
    output logic [DATA_WIDTH-1:0] outport_Data,
    output logic                  dev_valid,
    output logic [DATA_WIDTH-1:0] dev_data,
    input  logic                  dev_ready,
    output logic                  outport_busy,
    output logic [ADDR_BITS:0]    fifo_count,
    output logic                  overflow
`ifdef OUTPORT_PARITY_EN
    ,
    output logic                  dev_parity
`endif
);

    // state | meaning
    // IDLE  | nothing offered to the device
    // SEND  | dev_data valid, waiting for dev_ready
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [ADDR_BITS:0]   FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   COUNT_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

    state_t                 state, state_next;
    logic                   enable_q;
    logic                   capture, push, pop, drop, full;
    logic [ADDR_BITS-1:0]   wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
`ifdef OUTPORT_PARITY_EN
    logic                   mem_par [DEPTH];
`endif

    assign full         = (fifo_count == FULL_COUNT);
    assign outport_busy = full;
    assign dev_valid    = (state == SEND);
    assign capture      = outport_enable & ~enable_q;
    // A pop frees a slot in the same cycle, so a capture while full still lands.
    assign push         = capture & (~full | pop);
    assign drop         = capture & full & ~pop;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (dev_ready) begin
                    if (fifo_count != '0) pop = 1'b1;
                    else                  state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            enable_q     <= 1'b0;
            outport_Data <= '0;
            dev_data     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            state    <= state_next;
            enable_q <= outport_enable;
            if (capture) outport_Data <= bus_Data;
            if (push)    wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                dev_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (drop) overflow <= 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + COUNT_ONE;
            else if (!push && pop) fifo_count <= fifo_count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= bus_Data;
    end

`ifdef OUTPORT_PARITY_EN
    always_ff @(posedge clk) begin
        if (push && !clear) mem_par[wr_ptr] <= ^bus_Data;
    end

    always_ff @(posedge clk) begin
        if (clear)    dev_parity <= 1'b0;
        else if (pop) dev_parity <= mem_par[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_outport_unit.sv
// Self-checking bench for outport_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_outport_unit;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AB    = 2;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          outport_enable = 1'b0;
    logic [DW-1:0] bus_Data = '0;
    logic          dev_ready = 1'b0;
    logic [DW-1:0] outport_Data, dev_data;
    logic          dev_valid, outport_busy, overflow;
    logic [AB:0]   fifo_count;
`ifdef OUTPORT_PARITY_EN
    logic          dev_parity;
`endif

    outport_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk(clk), .clear(clear), .outport_enable(outport_enable), .bus_Data(bus_Data),
        .outport_Data(outport_Data), .dev_valid(dev_valid), .dev_data(dev_data),
        .dev_ready(dev_ready), .outport_busy(outport_busy), .fifo_count(fifo_count),
        .overflow(overflow)
`ifdef OUTPORT_PARITY_EN
        , .dev_parity(dev_parity)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of pending words plus the word on offer.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_delivered[$];
    logic [DW-1:0] m_cur, m_out;
    logic          m_valid, m_ovf, m_en_prev;
    bit            m_ok = 0;

    always @(posedge clk) begin
        if (clear) begin
            m_q.delete();
            m_cur = '0; m_out = '0; m_valid = 0; m_ovf = 0; m_en_prev = 0;
            m_ok = 1;
        end else begin
            bit cap, do_pop;
            cap    = outport_enable && !m_en_prev;
            do_pop = (m_q.size() > 0) && (!m_valid || dev_ready);
            if (m_valid && dev_ready) m_delivered.push_back(m_cur);
            if (do_pop) begin
                m_cur   = m_q.pop_front();
                m_valid = 1;
            end else if (m_valid && dev_ready) begin
                m_valid = 0;
            end
            if (cap) begin
                m_out = bus_Data;
                if (m_q.size() < DEPTH) m_q.push_back(bus_Data);
                else                    m_ovf = 1;
            end
            m_en_prev = outport_enable;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            check("valid",    DW'(dev_valid), DW'(m_valid));
            check("dev_data", dev_data, m_cur);
            check("out_data", outport_Data, m_out);
            check("count",    DW'(fifo_count), DW'(m_q.size()));
            check("busy",     DW'(outport_busy), DW'(m_q.size() == DEPTH));
            check("overflow", DW'(overflow), DW'(m_ovf));
`ifdef OUTPORT_PARITY_EN
            check("parity",   DW'(dev_parity), DW'(^m_cur));
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        outport_enable = 1'b1; bus_Data = d;
        cycles(1);
        outport_enable = 1'b0;
        cycles(1);
    endtask

    task automatic do_clear();
        clear = 1'b1; cycles(1); clear = 1'b0;
    endtask

    initial begin
        cycles(2);
        clear = 1'b0;
        check("rst_valid", DW'(dev_valid), 0);
        check("rst_data",  dev_data, 0);
        check("rst_count", DW'(fifo_count), 0);

        // Held enable stores exactly one word
        dev_ready = 1'b0; outport_enable = 1'b1; bus_Data = 32'h1234_5678;
        cycles(4);
        outport_enable = 1'b0;
        cycles(1);
        check("hold_valid", DW'(dev_valid), 1);
        check("hold_count", DW'(fifo_count), 0);
        check("hold_dev",   dev_data, 32'h1234_5678);
        check("hold_out",   outport_Data, 32'h1234_5678);

        // Clear held two cycles mid-SEND
        do_clear();
        pulse(32'h0000_00AA);
        cycles(1);
        check("aa_dev", dev_data, 32'h0000_00AA);
        clear = 1'b1; cycles(2); clear = 1'b0;
        check("clr_valid", DW'(dev_valid), 0);
        check("clr_count", DW'(fifo_count), 0);
        check("clr_ovf",   DW'(overflow), 0);
        check("clr_out",   outport_Data, 0);

        // Three pulses with ready held high, delivered in order
        do_clear();
        m_delivered.delete();
        dev_ready = 1'b1;
        pulse(32'h11); pulse(32'h22); pulse(32'h33);
        cycles(4);
        check("seq_n", DW'(m_delivered.size()), 3);
        if (m_delivered.size() == 3) begin
            check("seq0", m_delivered[0], 32'h11);
            check("seq1", m_delivered[1], 32'h22);
            check("seq2", m_delivered[2], 32'h33);
        end

        // Six pulses with ready low: one on offer, four stored, sixth dropped
        dev_ready = 1'b0;
        do_clear();
        m_delivered.delete();
        for (int i = 1; i <= 6; i++) pulse(DW'(i));
        check("ovf_dev",   dev_data, 32'h1);
        check("ovf_count", DW'(fifo_count), 4);
        check("ovf_busy",  DW'(outport_busy), 1);
        check("ovf_flag",  DW'(overflow), 1);
        check("ovf_out",   outport_Data, 32'h6);
        dev_ready = 1'b1;
        cycles(8);
        check("drain_n", DW'(m_delivered.size()), 5);
        for (int i = 0; i < m_delivered.size() && i < 5; i++)
            check("drain_w", m_delivered[i], DW'(i + 1));
        check("drain_ovf", DW'(overflow), 1);

        // Capture on the same edge as a pop while full
        dev_ready = 1'b0;
        do_clear();
        for (int i = 1; i <= 5; i++) pulse(DW'(i));
        check("full_count", DW'(fifo_count), 4);
        dev_ready = 1'b1; outport_enable = 1'b1; bus_Data = 32'h77;
        cycles(1);
        dev_ready = 1'b0; outport_enable = 1'b0;
        check("pp_count", DW'(fifo_count), 4);
        check("pp_ovf",   DW'(overflow), 0);
        check("pp_dev",   dev_data, 32'h2);

`ifdef OUTPORT_PARITY_EN
        do_clear();
        pulse(32'h0000_0007);
        check("par7", DW'(dev_parity), 1);
        do_clear();
        pulse(32'h0000_0003);
        check("par3", DW'(dev_parity), 0);
`endif

        // Randomized traffic
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            clear          = ($urandom_range(0, 199) == 0);
            outport_enable = ($urandom_range(0, 2) == 0);
            bus_Data       = $urandom();
            dev_ready      = ($urandom_range(0, 3) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            cycles(1);
        end
        clear = 1'b0; outport_enable = 1'b0; dev_ready = 1'b1;
        cycles(10);
        check("end_count", DW'(fifo_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
